// File: rtl/dff_res_pkg.sv
// Shared constants and types for dff_res users.
package dff_res_pkg;
  localparam logic DFF_RES_DEFAULT_RST = 1'b0;

  typedef logic [2:0] cnt3_t;
endpackage

// File: rtl/dff_res_bit.sv
// Single-bit register cell with async active-low reset to RST_BIT.
// Optional load enable when DFF_RES_CLK_EN is defined.
module dff_res_bit
  import dff_res_pkg::*;
#(
  parameter logic RST_BIT = DFF_RES_DEFAULT_RST
) (
  input  logic d,
  input  logic clk,
  input  logic reset,
`ifdef DFF_RES_CLK_EN
  input  logic en,
`endif
  output logic q
);
  logic r_q;

`ifdef DFF_RES_CLK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  r_q <= RST_BIT;
    else if (en) r_q <= d;
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= RST_BIT;
    else        r_q <= d;
  end
`endif

  assign q = r_q;
endmodule

// File: rtl/dff_res.sv
// WIDTH-bit register with async active-low reset to RESET_VAL, built from bit cells.
// Defining DFF_RES_CLK_EN adds a load-enable port en after reset.
module dff_res
  import dff_res_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter     RESET_VAL = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset,
`ifdef DFF_RES_CLK_EN
  input  logic             en,
`endif
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VAL);

  // Elaboration-time parameter sanity checks.
  generate
    if (WIDTH < 1) begin : gen_chk_width
      $error("dff_res: WIDTH must be >= 1");
    end
    if ((RESET_VAL >> WIDTH) != 0) begin : gen_chk_rst
      $error("dff_res: RESET_VAL wider than WIDTH");
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : gen_bit
      dff_res_bit #(
        .RST_BIT (L_RST[i])
      ) u_bit (
        .d     (d[i]),
        .clk   (clk),
        .reset (reset),
`ifdef DFF_RES_CLK_EN
        .en    (en),
`endif
        .q     (q[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_dff_res.sv
// Self-checking bench for dff_res (WIDTH=3, RESET_VAL=0); covers DFF_RES_CLK_EN when defined.
module tb_dff_res;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] d;
  logic         en;
  logic [W-1:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  dff_res #(.WIDTH(W), .RESET_VAL(3'b000)) dut (
    .d     (d),
    .clk   (clk),
    .reset (reset),
`ifdef DFF_RES_CLK_EN
    .en    (en),
`endif
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; d = 3'b111; en = 1'b1;
    #1;
    n_tests++;
    if (q !== 3'b000) begin
      n_fail++; $display("FAIL reset_state q=%b exp=000", q);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    reset = 1'b1; d = 3'b110; en = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (q !== 3'b110) begin
      n_fail++; $display("FAIL load q=%b exp=110", q);
    end
    #2 d = 3'b001;
    #1;
    n_tests++;
    if (q !== 3'b110) begin
      n_fail++; $display("FAIL load_hold_between_edges q=%b exp=110", q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    reset = 1'b1; d = 3'b101; en = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (q !== 3'b101) begin
      n_fail++; $display("FAIL async_preload q=%b exp=101", q);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (q !== 3'b000) begin
      n_fail++; $display("FAIL async_reset_midcycle q=%b exp=000", q);
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    reset = 1'b0; d = 3'b111; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (q !== 3'b000) begin
        n_fail++; $display("FAIL release_hold edge=%0d q=%b exp=000", k, q);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (q !== 3'b000) begin
      n_fail++; $display("FAIL release_no_edge q=%b exp=000", q);
    end
    @(posedge clk); #1;
    n_tests++;
    if (q !== 3'b111) begin
      n_fail++; $display("FAIL release_first_edge q=%b exp=111", q);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    reset = 1'b1; d = 3'b011; en = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (q !== 3'b000) begin
      n_fail++; $display("FAIL collision q=%b exp=000", q);
    end
  endtask

  task automatic test_counter();
    logic [W-1:0] exp_q;
    @(negedge clk);
    reset = 1'b0; en = 1'b1; d = 3'b000;
    #1;
    @(negedge clk);
    reset = 1'b1;
    exp_q = 3'b000;
    for (int k = 0; k < 9; k++) begin
      d = q + 3'd1;
      @(posedge clk); #1;
      exp_q = W'((k + 1) % 8);
      n_tests++;
      if (q !== exp_q) begin
        n_fail++; $display("FAIL counter step=%0d q=%b exp=%b", k, q, exp_q);
      end
      @(negedge clk);
    end
  endtask

`ifdef DFF_RES_CLK_EN
  task automatic test_enable();
    @(negedge clk);
    reset = 1'b1; en = 1'b1; d = 3'b101;
    @(posedge clk); #1;
    @(negedge clk);
    en = 1'b0; d = 3'b010;
    @(posedge clk); #1;
    n_tests++;
    if (q !== 3'b101) begin
      n_fail++; $display("FAIL en0_hold q=%b exp=101", q);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (q !== 3'b010) begin
      n_fail++; $display("FAIL en1_load q=%b exp=010", q);
    end
    @(negedge clk);
    en = 1'b0; reset = 1'b0;
    #1;
    n_tests++;
    if (q !== 3'b000) begin
      n_fail++; $display("FAIL en0_reset q=%b exp=000", q);
    end
  endtask
`endif

  // Reference: reset low forces 0; otherwise each rising edge loads d when enabled.
  task automatic test_random();
    logic [W-1:0] model;
    logic         rst_hit;
    @(negedge clk);
    reset = 1'b0; en = 1'b1;
    #1;
    model = 3'b000;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      rst_hit = ($urandom_range(0, 6) == 0);
      d       = W'($urandom);
`ifdef DFF_RES_CLK_EN
      en      = 1'($urandom);
`else
      en      = 1'b1;
`endif
      reset   = ~rst_hit;
      #1;
      if (rst_hit) begin
        model = 3'b000;
        n_tests++;
        if (q !== model) begin
          n_fail++; $display("FAIL rand_async it=%0d q=%b exp=%b", k, q, model);
        end
      end
      @(posedge clk); #1;
      if (reset && en) model = d;
      n_tests++;
      if (q !== model) begin
        n_fail++; $display("FAIL rand_edge it=%0d q=%b exp=%b d=%b en=%b rst=%b",
                           k, q, model, d, en, reset);
      end
    end
  endtask

  initial begin
    reset = 1'b1; d = '0; en = 1'b1;
    test_reset();
    test_load();
    test_async_reset();
    test_release();
    test_collision();
    test_counter();
`ifdef DFF_RES_CLK_EN
    test_enable();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
